// File: rtl/square_pulse_sequencer.sv
// square_pulse_sequencer: front-end controller for square_puls_generator.
// Generates the phase ramp, the per-sample strobe and a period-stable threshold,
// and sequences runs of a programmed number of periods.
// Optional build macro SQUARE_SEQ_AUTO_RELOAD_EN: accept a config word during RUN
// and apply it at the next period wrap.
module square_pulse_sequencer #(
    parameter int N_FRAC  = 7,
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [N_FRAC:0]     cfg_threshold_i,
    input  logic [N_FRAC:0]     cfg_step_i,
    input  logic [DIV_W-1:0]    cfg_divider_i,
    input  logic [BURST_W-1:0]  cfg_bursts_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic [N_FRAC:0]     counter_value_o,
    output logic [N_FRAC:0]     threshold_o,
    output logic                next_counter_value_strobe_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int W = N_FRAC + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       thr_q, thr_d, step_q, step_d, p_q, p_d;
    logic [DIV_W-1:0]   div_q, div_d, div_cnt_q, div_cnt_d;
    logic [BURST_W-1:0] bursts_q, bursts_d, rem_q, rem_d;
    logic               strobe_q, strobe_d;

    logic               accept, sample, wrap, to_idle;
    logic [W-1:0]       step_eff;
    logic [W:0]         sum_w;

`ifdef SQUARE_SEQ_AUTO_RELOAD_EN
    logic               pend_vld_q, pend_vld_d;
    logic [W-1:0]       pend_thr_q, pend_thr_d, pend_step_q, pend_step_d;
    logic [DIV_W-1:0]   pend_div_q, pend_div_d;
    logic [BURST_W-1:0] pend_bursts_q, pend_bursts_d;

    assign cfg_ready_o = (state_q == IDLE) || ((state_q == RUN) && !pend_vld_q);
`else
    assign cfg_ready_o = (state_q == IDLE);
`endif

    assign accept   = cfg_valid_i && cfg_ready_o;
    // A zero step would stall the ramp forever; treat it as the smallest step.
    assign step_eff = (step_q == '0) ? W'(1) : step_q;
    assign sum_w    = {1'b0, p_q} + {1'b0, step_eff};
    assign sample   = (div_cnt_q == div_q);

    // Next-state, phase/divider/burst bookkeeping and config capture.
    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        step_d    = step_q;
        div_d     = div_q;
        bursts_d  = bursts_q;
        p_d       = p_q;
        div_cnt_d = div_cnt_q;
        rem_d     = rem_q;
        strobe_d  = 1'b0;
        wrap      = 1'b0;
        to_idle   = 1'b0;
`ifdef SQUARE_SEQ_AUTO_RELOAD_EN
        pend_vld_d    = pend_vld_q;
        pend_thr_d    = pend_thr_q;
        pend_step_d   = pend_step_q;
        pend_div_d    = pend_div_q;
        pend_bursts_d = pend_bursts_q;
        if (accept && state_q == RUN) begin
            pend_vld_d    = 1'b1;
            pend_thr_d    = cfg_threshold_i;
            pend_step_d   = cfg_step_i;
            pend_div_d    = cfg_divider_i;
            pend_bursts_d = cfg_bursts_i;
        end else if (accept) begin
`else
        if (accept) begin
`endif
            thr_d    = cfg_threshold_i;
            step_d   = cfg_step_i;
            div_d    = cfg_divider_i;
            bursts_d = cfg_bursts_i;
        end

        case (state_q)
            IDLE: begin
                // Stop has priority over start; a word accepted now feeds this run.
                if (start_i && !stop_i) begin
                    state_d   = RUN;
                    strobe_d  = 1'b1;
                    p_d       = '0;
                    div_cnt_d = '0;
                    rem_d     = accept ? cfg_bursts_i : bursts_q;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d   = IDLE;
                    to_idle   = 1'b1;
                    p_d       = '0;
                    div_cnt_d = '0;
                end else if (sample) begin
                    div_cnt_d = '0;
                    wrap      = sum_w[W];
                    if (sum_w[W] && rem_q == BURST_W'(1)) begin
                        // Last period finished: swallow this sample point.
                        state_d = DONE;
                        p_d     = '0;
                    end else begin
                        if (sum_w[W] && rem_q != '0) rem_d = rem_q - BURST_W'(1);
                        p_d      = sum_w[W-1:0];
                        strobe_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                to_idle = 1'b1;
            end
            default: state_d = IDLE;
        endcase

`ifdef SQUARE_SEQ_AUTO_RELOAD_EN
        // Pending word lands on a period boundary so the threshold is period-stable.
        if (pend_vld_q && (wrap || to_idle)) begin
            pend_vld_d = 1'b0;
            thr_d      = pend_thr_q;
            step_d     = pend_step_q;
            div_d      = pend_div_q;
            bursts_d   = pend_bursts_q;
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            thr_q     <= '0;
            step_q    <= '0;
            div_q     <= '0;
            bursts_q  <= '0;
            p_q       <= '0;
            div_cnt_q <= '0;
            rem_q     <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            thr_q     <= thr_d;
            step_q    <= step_d;
            div_q     <= div_d;
            bursts_q  <= bursts_d;
            p_q       <= p_d;
            div_cnt_q <= div_cnt_d;
            rem_q     <= rem_d;
            strobe_q  <= strobe_d;
        end
    end

`ifdef SQUARE_SEQ_AUTO_RELOAD_EN
    // Pending reload registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_vld_q    <= 1'b0;
            pend_thr_q    <= '0;
            pend_step_q   <= '0;
            pend_div_q    <= '0;
            pend_bursts_q <= '0;
        end else begin
            pend_vld_q    <= pend_vld_d;
            pend_thr_q    <= pend_thr_d;
            pend_step_q   <= pend_step_d;
            pend_div_q    <= pend_div_d;
            pend_bursts_q <= pend_bursts_d;
        end
    end
`endif

    // Offset-binary phase to two's complement: flip the MSB.
    assign counter_value_o             = {~p_q[W-1], p_q[W-2:0]};
    assign threshold_o                 = thr_q;
    assign next_counter_value_strobe_o = strobe_q;
    assign busy_o                      = (state_q == RUN);
    assign done_o                      = (state_q == DONE);

endmodule

// File: tb/tb_square_pulse_sequencer.sv
// Self-checking bench for square_pulse_sequencer (default build, reload feature
// exercised only when SQUARE_SEQ_AUTO_RELOAD_EN is defined).
module tb_square_pulse_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [7:0]  cfg_threshold_i = '0;
    logic [7:0]  cfg_step_i = '0;
    logic [15:0] cfg_divider_i = '0;
    logic [7:0]  cfg_bursts_i = '0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [7:0]  counter_value_o;
    logic [7:0]  threshold_o;
    logic        next_counter_value_strobe_o;
    logic        busy_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;

    square_pulse_sequencer #(.N_FRAC(7), .DIV_W(16), .BURST_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_threshold_i(cfg_threshold_i), .cfg_step_i(cfg_step_i),
        .cfg_divider_i(cfg_divider_i), .cfg_bursts_i(cfg_bursts_i),
        .start_i(start_i), .stop_i(stop_i),
        .counter_value_o(counter_value_o), .threshold_o(threshold_o),
        .next_counter_value_strobe_o(next_counter_value_strobe_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: cycle c (1 = cycle after start edge) of a run. Strobe i carries
    // phase i*step mod 256; the run holds ceil(bursts*256/step) strobes, one every
    // div+1 cycles, then a single done cycle. bursts=0 never ends.
    task automatic model(input int c, input int s, input int div, input int b,
                         output bit stb, output bit bsy, output bit dn, output logic [7:0] val);
        int se, per, n, total, idx;
        se  = (s == 0) ? 1 : s;
        per = div + 1;
        n   = (b == 0) ? 1000000 : (b * 256 + se - 1) / se;
        total = 1 + n * per;
        stb = 0; bsy = 0; dn = 0; val = 8'h00;
        if (c < total) begin
            bsy = 1;
            stb = ((c - 1) % per) == 0;
            idx = (c - 1) / per;
            val = 8'(((idx * se) % 256) ^ 128);
        end else if (c == total) begin
            dn = 1;
        end
    endtask

    task automatic chk_cycle(input string tag, input int c, input int s, input int div, input int b);
        bit stb, bsy, dn;
        logic [7:0] val;
        model(c, s, div, b, stb, bsy, dn, val);
        chk({tag, " strobe"}, 32'(next_counter_value_strobe_o), 32'(stb));
        chk({tag, " busy"}, 32'(busy_o), 32'(bsy));
        chk({tag, " done"}, 32'(done_o), 32'(dn));
        if (stb) chk({tag, " value"}, 32'(counter_value_o), 32'(val));
    endtask

    // Program a word together with start, then follow the run to idle.
    task automatic run_check(input string tag, input logic [7:0] thr, input int s,
                             input int div, input int b);
        int se, total;
        se = (s == 0) ? 1 : s;
        total = 1 + ((b * 256 + se - 1) / se) * (div + 1);
        cfg_valid_i = 1; cfg_threshold_i = thr; cfg_step_i = 8'(s);
        cfg_divider_i = 16'(div); cfg_bursts_i = 8'(b); start_i = 1;
        @(negedge clk_i);
        cfg_valid_i = 0; start_i = 0;
        for (int c = 1; c <= total + 2; c++) begin
            chk_cycle(tag, c, s, div, b);
            chk({tag, " thr"}, 32'(threshold_o), 32'(thr));
`ifndef SQUARE_SEQ_AUTO_RELOAD_EN
            chk({tag, " ready"}, 32'(cfg_ready_o), 32'(c > total));
`endif
            @(negedge clk_i);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " value"}, 32'(counter_value_o), 32'h80);
        chk({tag, " thr"}, 32'(threshold_o), 32'h0);
        chk({tag, " strobe"}, 32'(next_counter_value_strobe_o), 32'h0);
        chk({tag, " busy"}, 32'(busy_o), 32'h0);
        chk({tag, " done"}, 32'(done_o), 32'h0);
        chk({tag, " ready"}, 32'(cfg_ready_o), 32'h1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        chk_reset_outputs("reset");
        rst_i = 1;
        @(negedge clk_i);

        // Basic burst and divider cases
        run_check("basic", 8'h00, 64, 0, 1);
        run_check("divider", 8'h11, 128, 2, 2);
        run_check("step0", 8'h22, 0, 0, 1);

        // start and stop together in IDLE: stop wins
        start_i = 1; stop_i = 1;
        @(negedge clk_i);
        start_i = 0; stop_i = 0;
        for (int c = 0; c < 3; c++) begin
            chk("startstop strobe", 32'(next_counter_value_strobe_o), 32'h0);
            chk("startstop busy", 32'(busy_o), 32'h0);
            @(negedge clk_i);
        end

        // Stop during a continuous run
        cfg_valid_i = 1; cfg_threshold_i = 8'h33; cfg_step_i = 8'd32;
        cfg_divider_i = 16'd1; cfg_bursts_i = 8'd0; start_i = 1;
        @(negedge clk_i);
        cfg_valid_i = 0; start_i = 0;
        for (int c = 1; c <= 21; c++) begin
            chk_cycle("cont", c, 32, 1, 0);
            @(negedge clk_i);
        end
        stop_i = 1;
        @(negedge clk_i);
        stop_i = 0;
        for (int c = 0; c < 4; c++) begin
            chk("stop strobe", 32'(next_counter_value_strobe_o), 32'h0);
            chk("stop done", 32'(done_o), 32'h0);
            chk("stop busy", 32'(busy_o), 32'h0);
            @(negedge clk_i);
        end
        run_check("afterstop", 8'h44, 96, 0, 1);

`ifndef SQUARE_SEQ_AUTO_RELOAD_EN
        // Config offered during RUN waits until IDLE
        cfg_valid_i = 1; cfg_threshold_i = 8'h05; cfg_step_i = 8'd128;
        cfg_divider_i = 16'd0; cfg_bursts_i = 8'd1; start_i = 1;
        @(negedge clk_i);
        start_i = 0; cfg_threshold_i = 8'hF9;
        for (int c = 1; c <= 4; c++) begin
            chk_cycle("hs", c, 128, 0, 1);
            chk("hs ready", 32'(cfg_ready_o), 32'(c == 4));
            chk("hs thr held", 32'(threshold_o), 32'h05);
            @(negedge clk_i);
        end
        cfg_valid_i = 0;
        chk("hs thr new", 32'(threshold_o), 32'hF9);
        @(negedge clk_i);
`else
        // Reload mid-period lands on the wrap strobe
        cfg_valid_i = 1; cfg_threshold_i = 8'h0A; cfg_step_i = 8'd64;
        cfg_divider_i = 16'd1; cfg_bursts_i = 8'd0; start_i = 1;
        @(negedge clk_i);
        start_i = 0; cfg_valid_i = 0;
        @(negedge clk_i);
        cfg_valid_i = 1; cfg_threshold_i = 8'd32;
        @(negedge clk_i);
        cfg_valid_i = 0;
        for (int c = 3; c <= 9; c++) begin
            chk_cycle("reload", c, 64, 1, 0);
            chk("reload thr", 32'(threshold_o), (c == 9) ? 32'd32 : 32'h0A);
            chk("reload ready", 32'(cfg_ready_o), 32'(c == 9));
            @(negedge clk_i);
        end
        stop_i = 1;
        @(negedge clk_i);
        stop_i = 0;
        @(negedge clk_i);
`endif

        // Randomized runs
        for (int k = 0; k < 6; k++) begin
            run_check("rand", 8'($urandom_range(0, 255)), int'($urandom_range(16, 255)),
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        // Reset asserted mid-run
        cfg_valid_i = 1; cfg_threshold_i = 8'h55; cfg_step_i = 8'd16;
        cfg_divider_i = 16'd0; cfg_bursts_i = 8'd0; start_i = 1;
        @(negedge clk_i);
        cfg_valid_i = 0; start_i = 0;
        repeat (5) @(negedge clk_i);
        rst_i = 0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk_i);
        rst_i = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("midrst done", 32'(done_o), 32'h0);
            chk("midrst strobe", 32'(next_counter_value_strobe_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
